// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared constants, state types and the sensor clamp helper for
// the fuzzy flood-risk serial front-end (fuzzy_sensor_rx, fuzzy_uart_rx).
package fuzzy_pkg;

    localparam logic [7:0] FRAME_HDR  = 8'hA5;
    localparam logic [7:0] SENSOR_MAX = 8'd100;

    typedef enum logic [1:0] {
        HUNT,
        GET_RAIN,
        GET_SOIL,
        GET_SUM
    } parse_state_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Membership functions expect 0..100.
    function automatic logic [7:0] clamp_sensor(input logic [7:0] v);
        return (v > SENSOR_MAX) ? SENSOR_MAX : v;
    endfunction

endpackage

// File: rtl/fuzzy_sensor_rx_if.sv
// fuzzy_sensor_rx_if: sensor line and decoded-reading bundle.
//   rx_in         UART serial line, idle high
//   rain_fall     last good rainfall, 0..100
//   soil_moisture last good soil moisture, 0..100
//   sample_valid  one-cycle pulse when both readings update
//   frame_err     one-cycle pulse on stop-bit or checksum error
//   stale         no fresh data
// master: the receiver block; slave: the consumer that drives the line
// and reads the results.
interface fuzzy_sensor_rx_if;
    logic       rx_in;
    logic [7:0] rain_fall;
    logic [7:0] soil_moisture;
    logic       sample_valid;
    logic       frame_err;
    logic       stale;

    modport master (
        input  rx_in,
        output rain_fall, soil_moisture, sample_valid, frame_err, stale
    );

    modport slave (
        output rx_in,
        input  rain_fall, soil_moisture, sample_valid, frame_err, stale
    );
endinterface

// File: rtl/fuzzy_uart_rx.sv
// fuzzy_uart_rx: 8N1 UART byte receiver with 2-flop synchronizer and
// mid-bit sampling.
//   clk, rst_n  system clock, async active-low reset
//   rx_in       asynchronous serial line, idle high
//   byte_data   received byte, valid while byte_valid is high
//   byte_valid  one-cycle pulse in the mid-stop-bit sample cycle (stop = 1)
//   byte_ferr   one-cycle pulse in the mid-stop-bit sample cycle (stop = 0)
module fuzzy_uart_rx
    import fuzzy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_ferr  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Glitch rejection: start must still be low at mid-bit.
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        byte_ferr = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Line held low (break): re-arm only once it returns high.
                cnt_d = '0;
                if (rx_sync) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/fuzzy_sensor_rx.sv
// fuzzy_sensor_rx: serial sensor front-end for the fuzzy flood-risk
// estimator. Receives A5/rain/soil/checksum frames, validates them and
// presents clamped registered readings with a sample_valid strobe.
//   clk, rst_n  system clock, async active-low reset
//   bus         fuzzy_sensor_rx_if.master (rx_in in; rain_fall,
//               soil_moisture, sample_valid, frame_err, stale out)
// Optional feature macro FUZZY_STALE_TIMEOUT_EN: after TIMEOUT_CYCLES
// without a good frame, stale goes high and both readings are forced to 0.
module fuzzy_sensor_rx
    import fuzzy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 104,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic                clk,
    input logic                rst_n,
    fuzzy_sensor_rx_if.master  bus
);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 4");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    logic [7:0] byte_data;
    logic       byte_valid, byte_ferr;

    fuzzy_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (bus.rx_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ferr  (byte_ferr)
    );

    parse_state_t ps_q, ps_d;
    logic [7:0]   rain_raw_q, rain_raw_d, soil_raw_q, soil_raw_d;
    logic [7:0]   rain_q, rain_d, soil_q, soil_d;
    logic         sv_q, sv_d, fe_q, fe_d;
    logic [7:0]   sum_raw;

    assign sum_raw = rain_raw_q + soil_raw_q;

`ifdef FUZZY_STALE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer_q;
    logic          stale_q, stale_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                timer_q <= '0;
        else if (sv_d)             timer_q <= '0;
        else if (timer_q != TO_VAL) timer_q <= timer_q + 1'b1;
    end
`endif

    always_comb begin
        ps_d       = ps_q;
        rain_raw_d = rain_raw_q;
        soil_raw_d = soil_raw_q;
        rain_d     = rain_q;
        soil_d     = soil_q;
        sv_d       = 1'b0;
        fe_d       = 1'b0;
`ifdef FUZZY_STALE_TIMEOUT_EN
        stale_d    = stale_q;
`endif
        if (byte_ferr) begin
            fe_d = 1'b1;
            ps_d = HUNT;
        end else if (byte_valid) begin
            case (ps_q)
                HUNT: if (byte_data == FRAME_HDR) ps_d = GET_RAIN;
                GET_RAIN: begin
                    rain_raw_d = byte_data;
                    ps_d       = GET_SOIL;
                end
                GET_SOIL: begin
                    soil_raw_d = byte_data;
                    ps_d       = GET_SUM;
                end
                GET_SUM: begin
                    ps_d = HUNT;
                    if (byte_data == sum_raw) begin
                        rain_d = clamp_sensor(rain_raw_q);
                        soil_d = clamp_sensor(soil_raw_q);
                        sv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
                default: ps_d = HUNT;
            endcase
        end
`ifdef FUZZY_STALE_TIMEOUT_EN
        if (sv_d) begin
            stale_d = 1'b0;
        end else if (timer_q == TO_VAL) begin
            stale_d = 1'b1;
            rain_d  = '0;
            soil_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q       <= HUNT;
            rain_raw_q <= '0;
            soil_raw_q <= '0;
            rain_q     <= '0;
            soil_q     <= '0;
            sv_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef FUZZY_STALE_TIMEOUT_EN
            stale_q    <= 1'b1;
`endif
        end else begin
            ps_q       <= ps_d;
            rain_raw_q <= rain_raw_d;
            soil_raw_q <= soil_raw_d;
            rain_q     <= rain_d;
            soil_q     <= soil_d;
            sv_q       <= sv_d;
            fe_q       <= fe_d;
`ifdef FUZZY_STALE_TIMEOUT_EN
            stale_q    <= stale_d;
`endif
        end
    end

    assign bus.rain_fall     = rain_q;
    assign bus.soil_moisture = soil_q;
    assign bus.sample_valid  = sv_q;
    assign bus.frame_err     = fe_q;
`ifdef FUZZY_STALE_TIMEOUT_EN
    assign bus.stale         = stale_q;
`else
    assign bus.stale         = 1'b0;
`endif

endmodule
